main_memory: RTL



---
 rtl/main_memory_if.sv | 25 ++
 rtl/main_memory.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/main_memory_if.sv
// Memory-port bundle between a cache (master) and the main_memory model (slave).
// Carries request, write data, registered read data and the access statistics.
interface main_memory_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int WORD_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [WORD_WIDTH-1:0] din;
  logic [WORD_WIDTH-1:0] dout;
  logic                  re;
  logic                  we;
  logic                  ready;
  logic [31:0]           reads;
  logic [31:0]           writes;

  modport master (
    output addr, din, re, we,
    input  dout, ready, reads, writes
  );

  modport slave (
    input  addr, din, re, we,
    output dout, ready, reads, writes
  );
endinterface

// File: rtl/main_memory.sv
// Main-memory model: programmable read/write latency followed by a BURST-word
// transfer that wraps at the end of the 2^SIZE_BITS word array.
module main_memory #(
  parameter int ADDR_WIDTH    = 64,
  parameter int WORD_WIDTH    = 64,
  parameter int SIZE_BITS     = 16,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4,
  parameter int BURST         = 1
) (
  input logic          clk,
  input logic          rst,
  main_memory_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_BEAT = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic                   ready_r;
  logic                   op_write_r;
  logic [SIZE_BITS-1:0]   base_r;
  logic [31:0]            wait_cnt_r;
  logic [31:0]            beat_cnt_r;
  logic [WORD_WIDTH-1:0]  dout_r;
  logic [31:0]            reads_r;
  logic [31:0]            writes_r;
  logic [WORD_WIDTH-1:0]  mem_r [0:(1<<SIZE_BITS)-1];

  logic                   accept_s;
  logic                   load_s;
  logic                   done_s;
  logic                   wr_en_s;
  logic [SIZE_BITS-1:0]   rd_addr_s;
  logic [SIZE_BITS-1:0]   wr_addr_s;
  logic                   unused_addr_s;

  // Upper address bits alias onto the array and are intentionally dropped.
  assign unused_addr_s = ^bus.addr;

  assign bus.dout   = dout_r;
  assign bus.ready  = ready_r;
  assign bus.reads  = reads_r;
  assign bus.writes = writes_r;

  // Next-state and per-cycle strobes of the access sequencer.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    load_s       = 1'b0;
    done_s       = 1'b0;
    wr_en_s      = 1'b0;
    rd_addr_s    = base_r;
    wr_addr_s    = base_r + SIZE_BITS'(beat_cnt_r);
    case (state_r)
      ST_IDLE: begin
        if (ready_r && (bus.re || bus.we)) begin
          accept_s     = 1'b1;
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // dout is loaded on the edge that enters each read beat.
        if (wait_cnt_r == 32'd0) begin
          state_next_s = ST_BEAT;
          load_s       = !op_write_r;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_BEAT: begin
        wr_en_s = op_write_r;
        if (beat_cnt_r == 32'(BURST - 1)) begin
          done_s       = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_BEAT;
          load_s       = !op_write_r;
          rd_addr_s    = base_r + SIZE_BITS'(beat_cnt_r + 32'd1);
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, request capture, read data and statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ready_r    <= 1'b0;
      op_write_r <= 1'b0;
      base_r     <= '0;
      wait_cnt_r <= 32'd0;
      beat_cnt_r <= 32'd0;
      dout_r     <= '0;
      reads_r    <= 32'd0;
      writes_r   <= 32'd0;
    end else begin
      state_r <= state_next_s;
      ready_r <= (state_next_s != ST_WAIT);
      if (accept_s) begin
        op_write_r <= !bus.re;
        base_r     <= bus.addr[SIZE_BITS-1:0];
        wait_cnt_r <= bus.re ? 32'(READ_LATENCY - 1) : 32'(WRITE_LATENCY - 1);
      end else if (state_r == ST_WAIT && wait_cnt_r != 32'd0) begin
        wait_cnt_r <= wait_cnt_r - 32'd1;
      end
      if (state_r == ST_WAIT) begin
        beat_cnt_r <= 32'd0;
      end else if (state_r == ST_BEAT) begin
        beat_cnt_r <= beat_cnt_r + 32'd1;
      end
      if (load_s) begin
        dout_r <= mem_r[rd_addr_s];
      end
      if (done_s && !op_write_r) begin
        reads_r <= reads_r + 32'd1;
      end
      if (done_s && op_write_r) begin
        writes_r <= writes_r + 32'd1;
      end
    end
  end

  // Storage array; a reset edge drops the write beat in flight.
  always_ff @(posedge clk) begin
    if (!rst && wr_en_s) begin
      mem_r[wr_addr_s] <= bus.din;
    end
  end

endmodule
